// File: rtl/spoc64_bdo_trunc.sv
// Output truncation/padding stage for the SpoC-64 bdo path: byte-granular masking of the
// processed block, two-word bdo presentation with byte-valid masks, and 10*-padded feedback.
module spoc64_bdo_trunc #(
    parameter int unsigned BLK_W    = 64,
    parameter int unsigned WORD_W   = 32,
    parameter logic [7:0]  PAD_BYTE = 8'h80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_init_trunc,
    input  logic                  i_en_trunc,
    input  logic [3:0]            i_blk_bytes,
    input  logic [BLK_W-1:0]      i_ct_in,
    input  logic                  i_bdo_complete,
    output logic [WORD_W-1:0]     o_bdo,
    output logic [WORD_W/8-1:0]   o_bdo_valid_bytes,
    output logic                  o_trunc_complete,
    output logic [BLK_W-1:0]      o_state_fb
);

    localparam int unsigned N_BYTES = BLK_W / 8;
    localparam int unsigned WB      = WORD_W / 8;
    localparam int unsigned CNT_W   = 4;

    logic [BLK_W-1:0]  r_mask;
    logic [CNT_W-1:0]  r_cnt;

    logic [CNT_W-1:0]  w_blk_eff;
    logic              w_step;
    logic [BLK_W-1:0]  w_masked;
    logic [BLK_W-1:0]  w_pad;
    logic [WB-1:0]     w_valid_hi;
    logic [WB-1:0]     w_valid_lo;

    // Block length saturates at a full block; a step only happens while bytes remain to clear.
    assign w_blk_eff = (i_blk_bytes > CNT_W'(N_BYTES)) ? CNT_W'(N_BYTES) : i_blk_bytes;
    assign w_step    = i_en_trunc && !i_init_trunc && (r_cnt > w_blk_eff);

    always_ff @(posedge clk) begin
        if (rst || i_init_trunc) begin
            r_mask <= '1;
            r_cnt  <= CNT_W'(N_BYTES);
        end else if (w_step) begin
            r_mask <= r_mask << 8;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    assign w_masked         = i_ct_in & r_mask;
    assign o_trunc_complete = (r_cnt <= w_blk_eff);
    assign o_bdo            = i_bdo_complete ? w_masked[WORD_W-1:0]
                                             : w_masked[BLK_W-1 -: WORD_W];

    // Valid bit order: MSB corresponds to the lowest byte index of the word.
    always_comb begin
        w_valid_hi = '0;
        w_valid_lo = '0;
        for (int j = 0; j < int'(WB); j++) begin
            w_valid_hi[WB-1-j] = r_mask[BLK_W-1-8*j];
            w_valid_lo[WB-1-j] = r_mask[WORD_W-1-8*j];
        end
    end

    assign o_bdo_valid_bytes = i_bdo_complete ? w_valid_lo : w_valid_hi;

    always_comb begin
        w_pad = '0;
        if (w_blk_eff < CNT_W'(N_BYTES)) begin
            w_pad = BLK_W'(PAD_BYTE) << (8 * (N_BYTES - 1 - 32'(w_blk_eff)));
        end
    end

    assign o_state_fb = w_masked | w_pad;

endmodule

// File: tb/tb_spoc64_bdo_trunc.sv
// Bench for spoc64_bdo_trunc: directed vector table, hand-written corner sequences, and
// randomized traffic against a byte-count reference model.
module tb_spoc64_bdo_trunc;

    localparam logic [63:0] CT = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_trunc, en_trunc, bdo_complete;
    logic [3:0]  blk_bytes;
    logic [63:0] ct_in;
    logic [31:0] bdo;
    logic [3:0]  bdo_valid_bytes;
    logic        trunc_complete;
    logic [63:0] state_fb;

    int n_chk  = 0;
    int n_pass = 0;
    int m_keep = 8;

    always #5 clk = ~clk;

    spoc64_bdo_trunc dut (
        .clk               (clk),
        .rst               (rst),
        .i_init_trunc      (init_trunc),
        .i_en_trunc        (en_trunc),
        .i_blk_bytes       (blk_bytes),
        .i_ct_in           (ct_in),
        .i_bdo_complete    (bdo_complete),
        .o_bdo             (bdo),
        .o_bdo_valid_bytes (bdo_valid_bytes),
        .o_trunc_complete  (trunc_complete),
        .o_state_fb        (state_fb)
    );

    typedef struct {
        logic [3:0]  blk;
        logic        sel;
        int          n_en;
        logic [31:0] bdo;
        logic [3:0]  vb;
        logic        tc;
        logic [63:0] fb;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: the block is a row of 8 bytes, of which the first m_keep survive.
    function automatic void model(input int keep, input logic [3:0] blk, input logic [63:0] ct,
                                  input logic sel, output logic [31:0] e_bdo,
                                  output logic [3:0] e_vb, output logic e_tc,
                                  output logic [63:0] e_fb);
        int eff;
        logic [7:0] b[8];
        eff = (int'(blk) > 8) ? 8 : int'(blk);
        for (int i = 0; i < 8; i++) b[i] = (i < keep) ? ct[63-8*i -: 8] : 8'h00;
        for (int i = 0; i < 8; i++) e_fb[63-8*i -: 8] = b[i];
        if (eff < 8) e_fb[63-8*eff -: 8] = e_fb[63-8*eff -: 8] | 8'h80;
        for (int j = 0; j < 4; j++) begin
            int idx;
            idx = 4*int'(sel) + j;
            e_bdo[31-8*j -: 8] = b[idx];
            e_vb[3-j] = (idx < keep);
        end
        e_tc = (keep <= eff);
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] e_bdo;
        logic [3:0]  e_vb;
        logic        e_tc;
        logic [63:0] e_fb;
        model(m_keep, blk_bytes, ct_in, bdo_complete, e_bdo, e_vb, e_tc, e_fb);
        chk({tag, ".bdo"},   64'(bdo),             64'(e_bdo));
        chk({tag, ".valid"}, 64'(bdo_valid_bytes), 64'(e_vb));
        chk({tag, ".tc"},    64'(trunc_complete),  64'(e_tc));
        chk({tag, ".fb"},    state_fb,             e_fb);
    endtask

    // One clock edge; the model applies the same update from the pre-edge inputs.
    task automatic tick();
        int nxt;
        int eff;
        eff = (int'(blk_bytes) > 8) ? 8 : int'(blk_bytes);
        nxt = m_keep;
        if (rst || init_trunc) nxt = 8;
        else if (en_trunc && m_keep > eff) nxt = m_keep - 1;
        @(posedge clk);
        #1;
        m_keep = nxt;
    endtask

    task automatic do_init(input logic [3:0] blk);
        blk_bytes  = blk;
        init_trunc = 1'b1;
        en_trunc   = 1'b0;
        tick();
        init_trunc = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{4'd8,  1'b0, 0, 32'h0123_4567, 4'b1111, 1'b1, 64'h0123_4567_89AB_CDEF};
        tbl[1] = '{4'd8,  1'b1, 0, 32'h89AB_CDEF, 4'b1111, 1'b1, 64'h0123_4567_89AB_CDEF};
        tbl[2] = '{4'd5,  1'b1, 3, 32'h8900_0000, 4'b1000, 1'b1, 64'h0123_4567_8980_0000};
        tbl[3] = '{4'd5,  1'b0, 3, 32'h0123_4567, 4'b1111, 1'b1, 64'h0123_4567_8980_0000};
        tbl[4] = '{4'd0,  1'b0, 8, 32'h0000_0000, 4'b0000, 1'b1, 64'h8000_0000_0000_0000};
        tbl[5] = '{4'd0,  1'b1, 8, 32'h0000_0000, 4'b0000, 1'b1, 64'h8000_0000_0000_0000};
        tbl[6] = '{4'd3,  1'b0, 5, 32'h0123_4500, 4'b1110, 1'b1, 64'h0123_4580_0000_0000};
        tbl[7] = '{4'd12, 1'b1, 0, 32'h89AB_CDEF, 4'b1111, 1'b1, 64'h0123_4567_89AB_CDEF};
        tbl[8] = '{4'd5,  1'b1, 2, 32'h89AB_0000, 4'b1100, 1'b0, 64'h0123_4567_89AB_0000};

        rst = 1'b1; init_trunc = 1'b0; en_trunc = 1'b0; bdo_complete = 1'b0;
        blk_bytes = 4'd8; ct_in = CT;
        tick();
        tick();
        rst = 1'b0;

        // Post-reset outputs
        chk("rst.bdo",   64'(bdo), 64'h0123_4567);
        chk("rst.valid", 64'(bdo_valid_bytes), 64'hF);
        chk("rst.tc8",   64'(trunc_complete), 64'd1);
        blk_bytes = 4'd4; #1;
        chk("rst.tc4",   64'(trunc_complete), 64'd0);

        // Directed vector table
        foreach (tbl[k]) begin
            ct_in = CT;
            bdo_complete = 1'b0;
            do_init(tbl[k].blk);
            en_trunc = 1'b1;
            repeat (tbl[k].n_en) tick();
            en_trunc = 1'b0;
            bdo_complete = tbl[k].sel;
            #1;
            chk($sformatf("vec%0d.bdo", k),   64'(bdo),             64'(tbl[k].bdo));
            chk($sformatf("vec%0d.valid", k), 64'(bdo_valid_bytes), 64'(tbl[k].vb));
            chk($sformatf("vec%0d.tc", k),    64'(trunc_complete),  64'(tbl[k].tc));
            chk($sformatf("vec%0d.fb", k),    state_fb,             tbl[k].fb);
            check_all($sformatf("vec%0d.model", k));
        end

        // Latency: blk_bytes=5 completes after exactly 3 en_trunc cycles
        bdo_complete = 1'b0;
        do_init(4'd5);
        chk("lat.tc_after_init", 64'(trunc_complete), 64'd0);
        en_trunc = 1'b1;
        n = 0;
        while (!trunc_complete && n < 12) begin tick(); n++; end
        en_trunc = 1'b0;
        chk("lat.cycles5", 64'(n), 64'd3);

        // Idempotence: extra en_trunc after completion keeps the mask
        do_init(4'd3);
        en_trunc = 1'b1;
        repeat (7) tick();
        en_trunc = 1'b0;
        bdo_complete = 1'b0; #1;
        chk("idem.valid", 64'(bdo_valid_bytes), 64'b1110);
        chk("idem.bdo",   64'(bdo), 64'h0123_4500);
        bdo_complete = 1'b1; #1;
        chk("idem.valid1", 64'(bdo_valid_bytes), 64'b0000);

        // Priority: init+en together leaves cnt at 8 (one more step needed for blk_bytes=7)
        do_init(4'd7);
        en_trunc = 1'b1; tick();
        init_trunc = 1'b1; tick();
        init_trunc = 1'b0; en_trunc = 1'b0;
        chk("prio.tc", 64'(trunc_complete), 64'd0);
        en_trunc = 1'b1; tick(); en_trunc = 1'b0;
        chk("prio.tc_after1", 64'(trunc_complete), 64'd1);

        // Reset mid-run aborts; a fresh init then needs 6 steps
        do_init(4'd2);
        en_trunc = 1'b1;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0; en_trunc = 1'b0;
        bdo_complete = 1'b1; #1;
        chk("rstmid.valid1", 64'(bdo_valid_bytes), 64'hF);
        chk("rstmid.tc",     64'(trunc_complete), 64'd0);
        check_all("rstmid.model");
        do_init(4'd2);
        en_trunc = 1'b1;
        n = 0;
        while (!trunc_complete && n < 20) begin tick(); n++; end
        en_trunc = 1'b0;
        chk("rstmid.cycles", 64'(n), 64'd6);

        // Randomized traffic against the reference model
        for (int it = 0; it < 400; it++) begin
            rst          = ($urandom % 40) == 0;
            init_trunc   = ($urandom % 8) == 0;
            en_trunc     = ($urandom % 10) < 6;
            bdo_complete = $urandom % 2;
            if (($urandom % 5) == 0) blk_bytes = 4'($urandom % 16);
            ct_in        = {$urandom, $urandom};
            #1;
            check_all($sformatf("rnd%0d", it));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
